// File: rtl/prog_loader_if.sv
// Load-stream and CPU read-port bundle for prog_loader; master is the stream/CPU side, slave is the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              cpu_run;
  logic              err;

  modport master (
    output in_data, in_valid, restart, rd_addr,
    input  in_ready, rd_data, cpu_run, err
  );

  modport slave (
    input  in_data, in_valid, restart, rd_addr,
    output in_ready, rd_data, cpu_run, err
  );
endinterface

// File: rtl/prog_loader.sv
// Length-prefixed byte stream into program RAM, then cpu_run; writes land on the accept edge, in_ready is a state decode.
// Optional trailing checksum byte under macro LOADER_CHECKSUM_EN; default build has no checksum and err tied low.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int REM_W = ADDR_W + 1;

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd2;
`endif
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [REM_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_xfer;
  logic              w_wr_en;
  logic [2:0]        w_data_done_state;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_csum;
`endif

  always_comb begin
    w_ready = (r_state == S_LEN) || (r_state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    w_ready = w_ready || (r_state == S_CSUM);
`endif
  end

  assign w_xfer  = bus.in_valid && w_ready;
  // restart wins over a simultaneous transfer, including the memory write
  assign w_wr_en = w_xfer && !bus.restart && (r_state == S_DATA);

`ifdef LOADER_CHECKSUM_EN
  assign w_csum            = r_sum + bus.in_data;
  assign w_data_done_state = S_CSUM;
`else
  assign w_data_done_state = S_RUN;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LEN;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else if (bus.restart) begin
      r_state <= S_LEN;
    end else if (w_xfer) begin
      case (r_state)
        S_LEN: begin
          // a zero length byte means a full-memory image
          r_remaining <= (bus.in_data == '0) ? REM_W'(DEPTH) : REM_W'(bus.in_data);
          r_wr_ptr    <= '0;
`ifdef LOADER_CHECKSUM_EN
          r_sum       <= '0;
`endif
          r_state     <= S_DATA;
        end
        S_DATA: begin
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_sum       <= w_csum;
`endif
          if (r_remaining == REM_W'(1)) begin
            r_state <= w_data_done_state;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          r_state <= (w_csum == '0) ? S_RUN : S_ERR;
        end
`endif
        S_RUN, S_ERR: ;
        default: r_state <= S_LEN;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.rd_data  = r_mem[bus.rd_addr];
  assign bus.cpu_run  = (r_state == S_RUN);
`ifdef LOADER_CHECKSUM_EN
  assign bus.err      = (r_state == S_ERR);
`else
  assign bus.err      = 1'b0;
`endif
endmodule
